// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter between an instruction cache (read-only)
// and a data cache (read/writeback) sharing one physical-memory port.
// One transaction in flight at a time; arbitration happens only from IDLE.
module pmem_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction cache
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  // data cache
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  // physical memory
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 1 = D was granted last
  logic              we_q, we_d;                  // latched op: 1 = write
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_req, d_req, grant_i, grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // Grant decision in IDLE; a tie goes to whoever was not granted last
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && d_req) begin
        grant_i = last_grant_q;
        grant_d = ~last_grant_q;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // State, round-robin pointer and transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next state; the request is captured at grant so later changes from the
  // requester cannot disturb the command already on the memory port
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = 1'b0;
          we_d         = 1'b0;
          addr_d       = i_pmem_address;
        end else if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = 1'b1;
          we_d         = d_pmem_write;  // write wins over a simultaneous read
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_wdata;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory command and cache responses; a withdrawn request loses its resp
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    arb_busy     = (state_q != IDLE);
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
    if (state_q == SERVE_I || state_q == SERVE_D) begin
      pmem_read  = ~we_q;
      pmem_write = we_q;
    end
    if (state_q == SERVE_I) i_pmem_resp = pmem_resp & i_req;
    if (state_q == SERVE_D) d_pmem_resp = pmem_resp & d_req;
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter. Inputs change 1ns after a rising edge,
// outputs are checked 3ns after a rising edge (clock period 10ns).
module tb_pmem_arbiter;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_pmem_read = 1'b0;
  logic [ADDR_W-1:0] i_pmem_address = '0;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [ADDR_W-1:0] d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic              arb_busy;

  int total = 0;
  int bad   = 0;

  localparam logic [LINE_W-1:0] BEEF = {4{32'hDEADBEEF}};

  pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                     input logic [LINE_W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move from input-drive time to check time inside the same cycle
  task automatic settle();
    #2;
  endtask

  initial begin
    // ---- reset state ----
    #12;
    chk("rst_busy", arb_busy, 0);
    chk("rst_rd", pmem_read, 0);
    chk("rst_wr", pmem_write, 0);
    chk("rst_iresp", i_pmem_resp, 0);
    chk("rst_dresp", d_pmem_resp, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    rst_n = 1'b1;

    // ---- I read 0x1230, resp after 3 cycles ----
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    pmem_rdata = {4{32'h0BADF00D}};
    settle();
    chk("s1_idle_rd", pmem_read, 0);           // cycle N
    chk("s1_idle_busy", arb_busy, 0);
    tick(); settle();                          // N+1
    chk("s1_rd", pmem_read, 1);
    chk("s1_wr", pmem_write, 0);
    chk("s1_addr", pmem_address, 16'h1230);
    chk("s1_busy", arb_busy, 1);
    chk("s1_irdata", i_pmem_rdata, {4{32'h0BADF00D}});
    chk("s1_drdata", d_pmem_rdata, {4{32'h0BADF00D}});
    tick(); settle();                          // N+2
    chk("s1_noresp", i_pmem_resp, 0);
    tick(); pmem_resp = 1'b1; settle();        // N+3
    chk("s1_iresp", i_pmem_resp, 1);
    chk("s1_dresp", d_pmem_resp, 0);
    tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0; settle();
    chk("s1_back_idle", arb_busy, 0);
    chk("s1_iresp_off", i_pmem_resp, 0);
    chk("s1_rd_off", pmem_read, 0);

    // ---- tie after reset: I first, then D, then I again ----
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 16'h1000;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    tick(); pmem_resp = 1'b1; settle();        // SERVE_I
    chk("s2_i_addr", pmem_address, 16'h1000);
    chk("s2_i_rd", pmem_read, 1);
    chk("s2_i_iresp", i_pmem_resp, 1);
    chk("s2_i_dresp", d_pmem_resp, 0);
    tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0; settle();
    chk("s2_gap_busy", arb_busy, 0);           // mandatory idle cycle
    chk("s2_gap_rd", pmem_read, 0);
    tick(); pmem_resp = 1'b1; i_pmem_read = 1'b1; settle();  // SERVE_D
    chk("s2_d_addr", pmem_address, 16'h2000);
    chk("s2_d_rd", pmem_read, 1);
    chk("s2_d_dresp", d_pmem_resp, 1);
    chk("s2_d_iresp", i_pmem_resp, 0);
    tick(); pmem_resp = 1'b0; settle();        // IDLE, both pending
    chk("s2_gap2_busy", arb_busy, 0);
    tick(); settle();
    chk("s2_alt_addr", pmem_address, 16'h1000); // tie back to I
    chk("s2_alt_busy", arb_busy, 1);
    pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;

    // ---- D write 0x4000 with read also high, address change mid-serve ----
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 16'h4000; d_pmem_wdata = BEEF;
    tick(); settle();
    chk("s3_wr", pmem_write, 1);
    chk("s3_rd", pmem_read, 0);
    chk("s3_addr", pmem_address, 16'h4000);
    chk("s3_wdata", pmem_wdata, BEEF);
    tick(); d_pmem_address = 16'h5000; d_pmem_wdata = '0; settle();
    tick(); settle();
    chk("s3_addr_hold", pmem_address, 16'h4000);
    chk("s3_wdata_hold", pmem_wdata, BEEF);
    pmem_resp = 1'b1; #1;
    chk("s3_dresp", d_pmem_resp, 1);
    chk("s3_iresp", i_pmem_resp, 0);
    tick(); pmem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; settle();
    chk("s3_idle", arb_busy, 0);

    // ---- I withdraws mid-serve ----
    i_pmem_read = 1'b1; i_pmem_address = 16'h3000;
    tick(); settle();
    chk("s4_rd", pmem_read, 1);
    tick(); i_pmem_read = 1'b0; settle();
    chk("s4_still_busy", arb_busy, 1);
    chk("s4_still_rd", pmem_read, 1);
    tick(); pmem_resp = 1'b1; settle();
    chk("s4_iresp_supp", i_pmem_resp, 0);
    chk("s4_dresp_supp", d_pmem_resp, 0);
    chk("s4_busy_resp", arb_busy, 1);
    tick(); pmem_resp = 1'b0; settle();
    chk("s4_idle", arb_busy, 0);

    // ---- reset during SERVE_D, then tie goes to I ----
    d_pmem_read = 1'b1; d_pmem_address = 16'h6000;
    tick(); settle();
    chk("s5_d_rd", pmem_read, 1);
    chk("s5_d_addr", pmem_address, 16'h6000);
    pmem_resp = 1'b1; rst_n = 1'b0; #1;       // no clock edge in between
    chk("s5_rst_busy", arb_busy, 0);
    chk("s5_rst_rd", pmem_read, 0);
    chk("s5_rst_wr", pmem_write, 0);
    chk("s5_rst_dresp", d_pmem_resp, 0);
    chk("s5_rst_addr", pmem_address, 0);
    pmem_resp = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h7000;
    #1; rst_n = 1'b1;
    tick(); settle();
    chk("s5_tie_addr", pmem_address, 16'h7000);
    chk("s5_tie_rd", pmem_read, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 128, meaning physical-memory line width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning byte-address width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port i_pmem_read  input  1  instruction-cache line-read request.
REQ-006 The block SHALL have port i_pmem_address  input  ADDR_W  instruction-cache line address.
REQ-007 The block SHALL have port i_pmem_rdata  output  LINE_W  line returned to the instruction cache.
REQ-008 The block SHALL have port i_pmem_resp  output  1  instruction-cache completion pulse.
REQ-009 The block SHALL have port d_pmem_read  input  1  data-cache line-read request.
REQ-010 The block SHALL have port d_pmem_write  input  1  data-cache line-writeback request.
REQ-011 The block SHALL have port d_pmem_address  input  ADDR_W  data-cache line address.
REQ-012 The block SHALL have port d_pmem_wdata  input  LINE_W  data-cache writeback line.
REQ-013 The block SHALL have port d_pmem_rdata  output  LINE_W  line returned to the data cache.
REQ-014 The block SHALL have port d_pmem_resp  output  1  data-cache completion pulse.
REQ-015 The block SHALL have port pmem_read / pmem_write  output  1 each  physical-memory commands.
REQ-016 The block SHALL have port pmem_address  output  ADDR_W  physical-memory address.
REQ-017 The block SHALL have port pmem_wdata  output  LINE_W  physical-memory write line.
REQ-018 The block SHALL have port pmem_rdata  input  LINE_W  physical-memory read line.
REQ-019 The block SHALL have port pmem_resp  input  1  physical-memory completion.
REQ-020 The block SHALL have port arb_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-022 An I request is i_pmem_read; a D request is d_pmem_read OR d_pmem_write.
REQ-023 In IDLE, a single pending request SHALL be granted on the next rising edge; with no request the FSM SHALL stay in IDLE.
REQ-024 When both requests are pending in IDLE, the grant SHALL go to the requester not recorded in the 1-bit last_grant register (round-robin).
REQ-025 On every grant, the block SHALL update last_grant and SHALL latch the address, the op (read or write) and, for D, the wdata into internal registers.
REQ-026 If d_pmem_read and d_pmem_write are both high at grant, write SHALL win and the latched op SHALL be write.
REQ-027 In SERVE_x, pmem_read/pmem_write/pmem_address/pmem_wdata SHALL be driven only from the latched registers, with exactly one of pmem_read/pmem_write high.
REQ-028 In IDLE, pmem_read and pmem_write SHALL both be 0.
REQ-029 Request-to-command latency SHALL be 1 cycle: a request seen in IDLE at cycle N drives a pmem command in cycle N+1.
REQ-030 In SERVE_x, the FSM SHALL remain in that state until pmem_resp=1, then return to IDLE on the next edge.
REQ-031 With pmem_resp=1 in SERVE_x, x_pmem_resp SHALL be 1 in that same cycle (combinational), and only if x still asserts its request.
REQ-032 If the granted requester withdraws its request mid-transaction, the block SHALL complete the pmem transaction and suppress the response; the other requester's resp SHALL stay 0.
REQ-033 The non-granted requester's resp SHALL always be 0.
REQ-034 i_pmem_rdata and d_pmem_rdata SHALL both combinationally mirror pmem_rdata.
REQ-035 Re-arbitration SHALL occur only from IDLE, which gives one mandatory idle cycle between back-to-back transactions.
REQ-036 A request arriving in the same cycle as pmem_resp SHALL be considered in IDLE on the following cycle.

Reset
REQ-037 While rst_n=0, the state SHALL be forced to IDLE asynchronously, with pmem_read=0, pmem_write=0, i_pmem_resp=0, d_pmem_resp=0, arb_busy=0, latched address/wdata=0, and last_grant=D (so the first tie goes to I).
REQ-038 Reset asserted mid-transaction SHALL abort the transaction immediately and drive no response.

Verification
REQ-039 The bench SHALL cover: I read only at address 0x1230, pmem_resp after 3 cycles -> pmem_read=1 with pmem_address=0x1230 from cycle N+1; i_pmem_resp pulses 1 cycle; d_pmem_resp stays 0.
REQ-040 The bench SHALL cover: I and D reads pending together after reset -> I served first; D served after one IDLE cycle; a second tie then goes to I again only after D has been served (alternation).
REQ-041 The bench SHALL cover: D write to 0x4000 with wdata=0xDEADBEEF repeated -> pmem_write=1, pmem_wdata matches, pmem_read=0; d_pmem_write and d_pmem_read both high -> write only.
REQ-042 The bench SHALL cover: d_pmem_address changes to 0x5000 mid-SERVE_D -> pmem_address stays 0x4000 until resp.
REQ-043 The bench SHALL cover: I withdraws its request mid-SERVE_I -> the FSM waits for pmem_resp, i_pmem_resp stays 0, then returns to IDLE.
REQ-044 The bench SHALL cover: rst_n dropped during SERVE_D -> outputs are 0 immediately without a clock edge; after release a tie is granted to I.
